// File: rtl/priority_encoder_pipe.sv
// Registered N-to-log2(N) request encoder, fixed-priority or round-robin,
// with one result register behind a valid/ready handshake.
module priority_encoder_pipe #(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter bit RR = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] data_in,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [N-1:0] out_onehot,
  output logic         out_zero
);

  localparam logic [W-1:0] LAST = W'(N-1);
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] oh_q, oh_d;
  logic         zero_q, zero_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic [W-1:0] base;
  logic [W-1:0] cand [N];
  logic         grant_any;
  logic [W-1:0] grant_idx;

  // Both operands stay below N, so one conditional subtract wraps the sum.
  function automatic logic [W-1:0] wrap_add(
    input logic [W-1:0] a,
    input int unsigned  b
  );
    int unsigned s;
    s = 32'(a) + b;
    if (s >= 32'(N)) s = s - 32'(N);
    return W'(s);
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign accept   = en && in_ready;
  assign base     = RR ? ptr_q : '0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = wrap_add(base, 32'(i));
    end
  end

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (data_in[cand[i]]) begin
        grant_any = 1'b1;
        grant_idx = cand[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    zero_d  = zero_q;
    ptr_d   = ptr_q;
    if (accept) begin
      valid_d = 1'b1;
      zero_d  = !grant_any;
      idx_d   = grant_any ? grant_idx : '0;
      oh_d    = grant_any ? (ONE << grant_idx) : '0;
      if (RR && grant_any) begin
        ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      zero_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      zero_q  <= zero_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid  = valid_q;
  assign data_out   = idx_q;
  assign out_onehot = oh_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Bench for priority_encoder_pipe: fixed N=8, round-robin N=8 and N=5,
// table vectors, directed corner sequences and a random run vs a model.
module tb_priority_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] data_in;
  logic       out_ready;

  logic       ir0, ov0, z0;
  logic [2:0] do0;
  logic [7:0] oh0;
  logic       ir1, ov1, z1;
  logic [2:0] do1;
  logic [7:0] oh1;
  logic       ir2, ov2, z2;
  logic [2:0] do2;
  logic [4:0] oh2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  priority_encoder_pipe #(.N(8), .RR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready),
    .data_out(do0), .out_onehot(oh0), .out_zero(z0)
  );

  priority_encoder_pipe #(.N(8), .RR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready),
    .data_out(do1), .out_onehot(oh1), .out_zero(z1)
  );

  priority_encoder_pipe #(.N(5), .RR(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in[4:0]),
    .in_ready(ir2), .out_valid(ov2), .out_ready(out_ready),
    .data_out(do2), .out_onehot(oh2), .out_zero(z2)
  );

  // Reference model state, one slot per instance.
  int mn  [3] = '{8, 8, 5};
  bit mrr [3] = '{1'b0, 1'b1, 1'b1};
  bit mv  [3];
  int midx[3];
  int moh [3];
  bit mz  [3];
  int mp  [3];

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       z;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // First set bit met when walking up from start, wrapping at n.
  function automatic int grant(int data, int n, int start);
    for (int i = 0; i < n; i++) begin
      int b;
      b = (start + i) % n;
      if (((data >> b) & 1) == 1) return b;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      mv[m] = 0; midx[m] = 0; moh[m] = 0; mz[m] = 0; mp[m] = 0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 3; m++) begin
      int d;
      int g;
      bit rdy;
      d   = int'(data_in) & ((1 << mn[m]) - 1);
      rdy = !mv[m] || out_ready;
      if (en && rdy) begin
        g = grant(d, mn[m], mrr[m] ? mp[m] : 0);
        mv[m] = 1;
        if (g < 0) begin
          midx[m] = 0; moh[m] = 0; mz[m] = 1;
        end else begin
          midx[m] = g; moh[m] = 1 << g; mz[m] = 0;
          if (mrr[m]) mp[m] = (g + 1) % mn[m];
        end
      end else if (out_ready) begin
        mv[m] = 0;
      end
    end
  endtask

  task automatic cmp(int m, logic v, logic [7:0] idx, logic [7:0] oh,
                     logic z);
    chk($sformatf("out_valid%0d", m), 32'(v), 32'(mv[m]));
    chk($sformatf("data_out%0d", m), 32'(idx), 32'(midx[m]));
    chk($sformatf("out_onehot%0d", m), 32'(oh), 32'(moh[m]));
    chk($sformatf("out_zero%0d", m), 32'(z), 32'(mz[m]));
  endtask

  task automatic cmp_all();
    cmp(0, ov0, 8'(do0), oh0, z0);
    cmp(1, ov1, 8'(do1), oh1, z1);
    cmp(2, ov2, 8'(do2), 8'(oh2), z2);
    chk("idx_range2", 32'(do2 <= 3'd4), 32'd1);
  endtask

  task automatic step();
    #1;
    chk("in_ready0", 32'(ir0), 32'(!mv[0] || out_ready));
    chk("in_ready1", 32'(ir1), 32'(!mv[1] || out_ready));
    chk("in_ready2", 32'(ir2), 32'(!mv[2] || out_ready));
    model_edge();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic drive(logic e, logic [7:0] d, logic r);
    en = e; data_in = d; out_ready = r;
  endtask

  // Reset asserted away from the clock edge; outputs must clear at once.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    @(posedge clk);
    #1;
    cmp_all();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1};
    tbl[2] = '{1'b1, 8'h08, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
    tbl[3] = '{1'b1, 8'h01, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
    tbl[4] = '{1'b1, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 1'b0};
    tbl[6] = '{1'b1, 8'hFE, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0};
    tbl[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0};

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].d, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(ov0), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_idx", i), 32'(do0), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d_oh", i), 32'(oh0), 32'(tbl[i].oh));
      chk($sformatf("tbl%0d_zero", i), 32'(z0), 32'(tbl[i].z));
    end

    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'hFF, 1'b1);
      step();
      chk($sformatf("rr_sweep%0d", i), 32'(do1), 32'(i % 8));
    end
    drive(1'b1, 8'h05, 1'b1);
    step();
    chk("rr_p1_05", 32'(do1), 32'd2);

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      chk($sformatf("idle_valid%0d", i), 32'(ov1), 32'd0);
    end
    drive(1'b1, 8'hFF, 1'b1);
    step();
    chk("rr_after_idle", 32'(do1), 32'd3);

    pulse_reset();
    chk("rst_valid", 32'(ov1), 32'd0);
    drive(1'b1, 8'hFF, 1'b1);
    step();
    chk("rr_after_rst", 32'(do1), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      case ($urandom_range(0, 3))
        0:       d = 8'h00;
        1:       d = 8'h01 << $urandom_range(0, 7);
        default: d = 8'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
      step();
      if (i == 200) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
